baseband_pulse_gen: RTL and testbench

Upstream stage of the per-bit RF pulse generators. Accepts a serial data bit stream over a valid/ready handshake and converts each bit into one fixed-length symbol frame. Each frame carries a single baseband pulse on either the bit-'0' or bit-'1' pulse line. Those lines drive the baseband pulse inputs of the RF pulse generators for bit '0' and bit '1'. The block also provides frame status and a running symbol count.

---
 rtl/baseband_pulse_gen.sv | 130 +++++++++++++
 tb/tb_baseband_pulse_gen.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/baseband_pulse_gen.sv
// baseband_pulse_gen
//   Converts a serial bit stream (valid/ready) into fixed-length symbol
//   frames. Each frame carries one baseband pulse on the line chosen by
//   the bit: baseband_pulse_0 for a '0', baseband_pulse_1 for a '1'.
//
// Ports
//   clk              rising-edge clock
//   rst_n            synchronous active-low reset
//   en               gates acceptance of new bits only
//   bit_in           data bit, latched on transfer
//   bit_valid        bit_in is valid
//   bit_ready        block accepts bit_in this cycle (combinational)
//   baseband_pulse_0 registered pulse for a '0' symbol
//   baseband_pulse_1 registered pulse for a '1' symbol
//   busy             registered, a frame is in progress
//   symbol_done      registered strobe in the last frame cycle
//   sym_count        completed frames, wraps modulo 2^16
module baseband_pulse_gen #(
    parameter int SYMBOL_CYCLES = 16,
    parameter int GUARD_CYCLES  = 2,
    parameter int PULSE_WIDTH   = 4,
    parameter int CNT_W         = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        bit_in,
    input  logic        bit_valid,
    output logic        bit_ready,
    output logic        baseband_pulse_0,
    output logic        baseband_pulse_1,
    output logic        busy,
    output logic        symbol_done,
    output logic [15:0] sym_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GUARD = 2'd1,
        PULSE = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_C        = CNT_W'(SYMBOL_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_START_C = CNT_W'(GUARD_CYCLES);
    // First frame cycle after the pulse. May alias to 0 when the pulse runs
    // to the end of the frame; that value is never reached by an increment.
    localparam logic [CNT_W-1:0] PULSE_END_C   = CNT_W'(GUARD_CYCLES + PULSE_WIDTH);
    localparam state_t           FIRST_STATE   = (GUARD_CYCLES == 0) ? PULSE : GUARD;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               bit_q, bit_d;
    logic               p0_q, p0_d;
    logic               p1_q, p1_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [15:0]        count_q, count_d;
    logic               frame_last;
    logic               xfer;

    assign frame_last = (state_q != IDLE) && (cnt_q == LAST_C);
    assign bit_ready  = rst_n && en && ((state_q == IDLE) || frame_last);
    assign xfer       = bit_valid && bit_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        count_d = count_q;

        if (frame_last) begin
            count_d = count_q + 16'd1;
        end

        if (xfer) begin
            // A transfer in the last frame cycle starts the next frame at the
            // same edge, so busy never drops between back-to-back symbols.
            state_d = FIRST_STATE;
            cnt_d   = '0;
            bit_d   = bit_in;
        end else if (frame_last) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (state_q != IDLE) begin
            cnt_d = cnt_q + CNT_W'(1);
            case (state_q)
                GUARD:   if (cnt_d == PULSE_START_C) state_d = PULSE;
                PULSE:   if (cnt_d == PULSE_END_C)   state_d = GAP;
                default: state_d = state_q;
            endcase
        end

        // Outputs are decoded from the next state so they register in step
        // with the frame cycle they describe.
        p0_d   = (state_d == PULSE) && !bit_d;
        p1_d   = (state_d == PULSE) &&  bit_d;
        busy_d = (state_d != IDLE);
        done_d = busy_d && (cnt_d == LAST_C);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= 1'b0;
            p0_q    <= 1'b0;
            p1_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            p0_q    <= p0_d;
            p1_q    <= p1_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

    assign baseband_pulse_0 = p0_q;
    assign baseband_pulse_1 = p1_q;
    assign busy             = busy_q;
    assign symbol_done      = done_q;
    assign sym_count        = count_q;

endmodule

// File: tb/tb_baseband_pulse_gen.sv
module tb_baseband_pulse_gen;

    localparam int S = 16;
    localparam int G = 2;
    localparam int P = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0, en = 1'b0, bit_in = 1'b0, bit_valid = 1'b0;
    logic        bit_ready, p0, p1, busy, done;
    logic [15:0] sym_count;

    logic        rst2_n = 1'b0, en2 = 1'b0, bit2 = 1'b0, valid2 = 1'b0;
    logic        ready2, q0, q1, busy2, done2;
    logic [15:0] cnt2;

    always #5 clk = ~clk;

    baseband_pulse_gen #(.SYMBOL_CYCLES(S), .GUARD_CYCLES(G), .PULSE_WIDTH(P), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(bit_ready), .baseband_pulse_0(p0), .baseband_pulse_1(p1),
        .busy(busy), .symbol_done(done), .sym_count(sym_count));

    baseband_pulse_gen #(.SYMBOL_CYCLES(16), .GUARD_CYCLES(0), .PULSE_WIDTH(16), .CNT_W(8)) dut2 (
        .clk(clk), .rst_n(rst2_n), .en(en2), .bit_in(bit2), .bit_valid(valid2),
        .bit_ready(ready2), .baseband_pulse_0(q0), .baseband_pulse_1(q1),
        .busy(busy2), .symbol_done(done2), .sym_count(cnt2));

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        b;
        logic [15:0] cnt;
    } exp_t;
    exp_t sb_q[$];

    // Expected pulse footprint within one frame: cycles G .. G+P-1.
    function automatic logic [255:0] exp_mask();
        logic [255:0] m = '0;
        for (int i = 0; i < S; i++) m[i] = (i >= G) && (i < G + P);
        return m;
    endfunction

    // Reference model: frame occupancy and position within the frame.
    logic        m_busy = 1'b0;
    int          m_k = 0;
    logic [15:0] m_count = '0;

    task automatic drive_cycle(input logic r, input logic e, input logic v, input logic b,
                               output logic xf);
        logic mr;
        exp_t x;
        rst_n = r; en = e; bit_valid = v; bit_in = b;
        #1;
        mr = r && e && (!m_busy || m_k == S - 1);
        chk("bit_ready", {31'd0, bit_ready}, {31'd0, mr});
        xf = v && mr;
        if (!r) begin
            m_busy = 1'b0; m_k = 0; m_count = '0;
            sb_q.delete();
        end else begin
            if (m_busy && m_k == S - 1) m_count = m_count + 16'd1;
            if (xf) begin
                x.b = b; x.cnt = m_count;
                sb_q.push_back(x);
                m_busy = 1'b1; m_k = 0;
            end else if (m_busy && m_k == S - 1) begin
                m_busy = 1'b0; m_k = 0;
            end else if (m_busy) begin
                m_k++;
            end
        end
        @(negedge clk);
        chk("busy", {31'd0, busy}, {31'd0, m_busy});
        chk("sym_count", {16'd0, sym_count}, {16'd0, m_count});
    endtask

    task automatic idle(input int n);
        logic xf;
        for (int i = 0; i < n; i++) drive_cycle(1'b1, 1'b1, 1'b0, 1'($urandom_range(0, 1)), xf);
    endtask

    // Monitor: reconstructs each frame from the outputs and compares it with
    // the scoreboard entry when symbol_done appears.
    logic         in_frm = 1'b0;
    int           idx = 0;
    logic [255:0] m0, m1;
    logic         pend_v = 1'b0;
    logic [15:0]  pend;

    always @(posedge clk) begin
        exp_t x;
        #1;
        if (!rst_n) begin
            chk("rst_outputs", {28'd0, p0, p1, busy, done}, 32'd0);
            chk("rst_count", {16'd0, sym_count}, 32'd0);
            in_frm = 1'b0;
            pend_v = 1'b0;
        end else begin
            if (pend_v) begin
                chk("count_inc", {16'd0, sym_count}, {16'd0, pend});
                pend_v = 1'b0;
            end
            if (p0 && p1) chk("exclusive", 32'd1, 32'd0);
            if (busy) begin
                if (!in_frm) begin
                    in_frm = 1'b1; idx = 0; m0 = '0; m1 = '0;
                end
                if (idx < 256) begin
                    m0[idx] = p0; m1[idx] = p1;
                end
                if (done) begin
                    if (sb_q.size() == 0) begin
                        chk("frame_unexpected", 32'd1, 32'd0);
                    end else begin
                        x = sb_q.pop_front();
                        chk("frame_len", idx, S - 1);
                        chk("pulse_sel", (x.b ? m1[31:0] : m0[31:0]), exp_mask() & 256'hFFFF_FFFF);
                        chk("pulse_other", (x.b ? m0[31:0] : m1[31:0]), 32'd0);
                        chk("done_count", {16'd0, sym_count}, {16'd0, x.cnt});
                        pend = x.cnt + 16'd1;
                        pend_v = 1'b1;
                    end
                    in_frm = 1'b0;
                end else begin
                    idx++;
                end
            end else begin
                if (in_frm) chk("frame_no_done", 32'd1, 32'd0);
                in_frm = 1'b0;
                chk("idle_lines", {29'd0, p0, p1, done}, 32'd0);
            end
        end
    end

    initial begin
        logic xf;
        logic v, b, e;
        logic [2:0] stream;
        int waited;

        @(negedge clk);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1, 1'b1, 1'b1, xf);

        // Single '0' frame.
        drive_cycle(1'b1, 1'b1, 1'b1, 1'b0, xf);
        chk("t1_xfer", {31'd0, xf}, 32'd1);
        idle(20);
        chk("t1_count", {16'd0, sym_count}, 32'd1);

        // Held valid with stream 1,0,1: back-to-back frames.
        stream = 3'b101;
        for (int j = 0; j < 3; j++) begin
            waited = 0;
            xf = 1'b0;
            while (!xf && waited < 40) begin
                drive_cycle(1'b1, 1'b1, 1'b1, stream[j], xf);
                waited++;
            end
            if (!xf) chk("t2_timeout", 32'd1, 32'd0);
        end
        idle(20);
        chk("t2_count", {16'd0, sym_count}, 32'd4);

        // en dropped at frame cycle 5 with valid high.
        drive_cycle(1'b1, 1'b1, 1'b1, 1'b1, xf);
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, xf);
        for (int i = 0; i < 20; i++) drive_cycle(1'b1, 1'b0, 1'b1, 1'b0, xf);
        drive_cycle(1'b1, 1'b1, 1'b1, 1'b0, xf);
        chk("t4_resume", {31'd0, xf}, 32'd1);
        idle(20);

        // Reset during the pulse, then a normal frame.
        drive_cycle(1'b1, 1'b1, 1'b1, 1'b1, xf);
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, xf);
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, xf);
        drive_cycle(1'b1, 1'b1, 1'b1, 1'b1, xf);
        idle(20);
        chk("t5_count", {16'd0, sym_count}, 32'd1);

        // Randomised traffic.
        v = 1'b0; b = 1'b0; xf = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (v && !xf) begin
                if ($urandom_range(0, 9) == 0) v = 1'b0;
            end else begin
                v = ($urandom_range(0, 3) != 0);
                b = 1'($urandom_range(0, 1));
            end
            e = ($urandom_range(0, 15) != 0);
            drive_cycle(1'b1, e, v, b, xf);
        end
        idle(20);
        chk("sb_empty", sb_q.size(), 0);

        // Counter wrap from 0xFFFF.
        force dut.count_q = 16'hFFFF;
        m_count = 16'hFFFF;
        idle(1);
        release dut.count_q;
        drive_cycle(1'b1, 1'b1, 1'b1, 1'b0, xf);
        idle(20);
        chk("wrap", {16'd0, sym_count}, 32'd0);
        chk("sb_empty_end", sb_q.size(), 0);

        // Zero guard, full-width pulse, back-to-back '0' bits.
        rst2_n = 1'b1; en2 = 1'b1;
        @(negedge clk);
        valid2 = 1'b1; bit2 = 1'b0;
        waited = 0;
        for (int c = 1; c <= 33; c++) begin
            @(posedge clk);
            #1;
            if (c <= 32) begin
                chk("g0_pulse0", {31'd0, q0}, 32'd1);
                chk("g0_pulse1", {31'd0, q1}, 32'd0);
                chk("g0_busy", {31'd0, busy2}, 32'd1);
                chk("g0_done", {31'd0, done2}, {31'd0, (c == 16 || c == 32)});
            end else begin
                chk("g0_end_busy", {30'd0, busy2, q0}, 32'd0);
                chk("g0_count", {16'd0, cnt2}, 32'd2);
            end
            if (done2) waited++;
            if (c == 17) valid2 = 1'b0;
        end
        chk("g0_strobes", waited, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
